mux_scan_n1: RTL and testbench
==============================

Name: mux_scan_n1

Overview:
- Parametrised, registered N:1 channel multiplexer; generalises the fixed 8:1 single-bit mux to CHANNELS inputs of WIDTH bits each.
- Adds an auto-scan mode that steps through channels round-robin with a programmable dwell time.
- Registered output with new-channel and wrap strobes.
- Used in board labs to drive LEDR/display from a bank of SW-sourced or internal data words.

Parameters:
- WIDTH, 1, bits per channel.
- CHANNELS, 8, number of input channels; power of two, >= 2.
- SEL_W, 3, select width; must equal log2(CHANNELS).
- DWELL, 4, cycles each channel is held in scan mode; >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel_in  input  SEL_W  channel select used in direct mode.
- mode  input  1  0 = direct, 1 = scan.
- hold  input  1  scan mode only: freezes channel index and dwell counter.
- data_out  output  WIDTH  registered selected channel data.
- sel_out  output  SEL_W  channel index that data_out came from.
- new_chan  output  1  one-cycle strobe: data_out is the first sample of a different channel.
- wrap  output  1  one-cycle strobe: scan advanced from channel CHANNELS-1 to 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - data_out = 0, sel_out = 0, new_chan = 0, wrap = 0.
  - state = DIRECT, scan_ch = 0, dwell_cnt = 0, first flag = 1.
  - Reset asserted mid-operation takes effect at the next edge regardless of mode or hold.
- State machine, two states, evaluated each edge:
  - DIRECT, mode=1 -> SCAN. scan_ch <= 0, dwell_cnt <= 0.
  - SCAN, mode=0 -> DIRECT.
  - Otherwise the state holds.
- Current channel cur_sel comes from the state register, not from mode:
  - DIRECT: cur_sel = sel_in (combinational).
  - SCAN: cur_sel = scan_ch.
- Datapath, latency 1 cycle:
  - data_out <= data_in[cur_sel*WIDTH +: WIDTH].
  - sel_out <= cur_sel.
  - data_out tracks the live input of the selected channel every cycle, including while hold=1.
- new_chan:
  - Next cycle it is 1 if (first flag) or (cur_sel != sel_out); otherwise 0.
  - The first flag clears after the first post-reset capture.
- Scan stepping, in SCAN with hold=0:
  - dwell_cnt < DWELL-1: dwell_cnt increments.
  - dwell_cnt == DWELL-1: dwell_cnt <= 0 and scan_ch <= scan_ch+1 (modulo CHANNELS).
  - If scan_ch was CHANNELS-1, wrap <= 1 for exactly one cycle, coincident with scan_ch becoming 0.
- Hold:
  - hold=1 in SCAN freezes scan_ch and dwell_cnt.
  - No wrap pulse while held; new_chan stays 0.
  - hold is ignored in DIRECT.
- Each channel is presented for exactly DWELL consecutive data_out cycles when hold=0.
- DWELL=1: channel advances every cycle; new_chan is high every cycle during steady scan.
- Re-entering SCAN always restarts at channel 0 with a full dwell, even if the previous scan stopped mid-sequence.
- Mode change and hold in the same cycle: the mode transition wins; the hold has no effect on that edge.
- wrap is never asserted in DIRECT or during the DIRECT->SCAN entry edge.
- Combinational selection is implemented as a generic indexed select (no fixed-size instance tree), so any legal CHANNELS/WIDTH elaborates.

Test Plan:
- Setup for all cases: WIDTH=4, CHANNELS=8, DWELL=3; channel k holds value k+8.
- Reset then direct:
  - rst=1 for 2 cycles; data_out=0, new_chan=0, wrap=0.
  - Release with mode=0, sel_in=5 -> next cycle data_out=13, sel_out=5, new_chan=1; following cycles new_chan=0.
- Direct switching:
  - sel_in 5->2 -> one cycle later data_out=10, sel_out=2, new_chan=1 for one cycle.
  - Change channel 2's input to 4'hF while selected -> data_out=F next cycle, new_chan=0.
- Scan sequence:
  - Set mode=1 -> data_out shows 8,8,8, then 9,9,9, ... through 15,15,15, then 8.
  - new_chan=1 on each first sample.
  - wrap=1 for exactly one cycle at the 7->0 advance.
- Hold:
  - During scan at channel 3, second dwell cycle, assert hold for 5 cycles -> data_out stays 11, no new_chan, no wrap.
  - Release -> channel 3 persists 1 more cycle, then advances to 12.
- Mode exit and re-entry:
  - Mid-scan at channel 6, set mode=0 with sel_in=1 -> next-next cycle data_out=9, new_chan=1.
  - Return mode=1 -> scan restarts at channel 0 (data_out=8) for 3 cycles.
- Reset mid-scan and DWELL=1 variant:
  - rst at channel 4 -> next cycle all outputs 0, state DIRECT.
  - With DWELL=1, scan yields new_chan=1 every cycle and wrap every 8 cycles.

Source files
------------

// File: rtl/mux_scan_n1.sv
// Registered N:1 channel multiplexer with a direct-select mode and an
// auto-scan mode that walks the channels round-robin with a fixed dwell.
module mux_scan_n1 #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      new_chan,
    output logic                      wrap
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  scanCh_q, scanCh_d;
    logic [DW_W-1:0]   dwellCnt_q, dwellCnt_d;
    logic              first_q, first_d;
    logic [WIDTH-1:0]  dataOut_q, dataOut_d;
    logic [SEL_W-1:0]  selOut_q, selOut_d;
    logic              newChan_q, newChan_d;
    logic              wrap_q, wrap_d;
    logic [SEL_W-1:0]  curSel;

    // The channel is chosen by the registered state, so a mode change only
    // redirects the datapath one edge after the state register has moved.
    always_comb begin
        state_d    = state_q;
        scanCh_d   = scanCh_q;
        dwellCnt_d = dwellCnt_q;
        wrap_d     = 1'b0;
        curSel     = (state_q == SCAN) ? scanCh_q : sel_in;

        case (state_q)
            DIRECT: begin
                if (mode) begin
                    state_d    = SCAN;
                    scanCh_d   = '0;
                    dwellCnt_d = '0;
                end
            end
            SCAN: begin
                if (!mode) begin
                    state_d = DIRECT;
                end else if (!hold) begin
                    if (dwellCnt_q == DWELL_LAST) begin
                        dwellCnt_d = '0;
                        scanCh_d   = scanCh_q + SEL_W'(1);
                        wrap_d     = (scanCh_q == LAST_CH);
                    end else begin
                        dwellCnt_d = dwellCnt_q + DW_W'(1);
                    end
                end
            end
            default: state_d = DIRECT;
        endcase

        dataOut_d = data_in[int'(curSel)*WIDTH +: WIDTH];
        selOut_d  = curSel;
        newChan_d = first_q || (curSel != selOut_q);
        first_d   = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIRECT;
            scanCh_q   <= '0;
            dwellCnt_q <= '0;
            first_q    <= 1'b1;
            dataOut_q  <= '0;
            selOut_q   <= '0;
            newChan_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scanCh_q   <= scanCh_d;
            dwellCnt_q <= dwellCnt_d;
            first_q    <= first_d;
            dataOut_q  <= dataOut_d;
            selOut_q   <= selOut_d;
            newChan_q  <= newChan_d;
            wrap_q     <= wrap_d;
        end
    end

    assign data_out = dataOut_q;
    assign sel_out  = selOut_q;
    assign new_chan = newChan_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_mux_scan_n1.sv
// Bench for mux_scan_n1: two instances (dwell 3 and dwell 1) share stimulus
// and are compared each cycle against a scan-position reference model.
module tb_mux_scan_n1;

    logic        clk;
    logic        rst;
    logic [31:0] dataIn;
    logic [2:0]  selIn;
    logic        mode;
    logic        hold;

    logic [3:0]  dataOutA, dataOutB;
    logic [2:0]  selOutA, selOutB;
    logic        newChanA, newChanB;
    logic        wrapA, wrapB;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    typedef struct {
        bit         inScan;
        int         pos;
        bit         first;
        logic [3:0] data;
        logic [2:0] sel;
        logic       nc;
        logic       wr;
    } model_t;

    model_t mA, mB;

    mux_scan_n1 #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(3)) dutA (
        .clk(clk), .rst(rst), .data_in(dataIn), .sel_in(selIn),
        .mode(mode), .hold(hold), .data_out(dataOutA), .sel_out(selOutA),
        .new_chan(newChanA), .wrap(wrapA)
    );

    mux_scan_n1 #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(1)) dutB (
        .clk(clk), .rst(rst), .data_in(dataIn), .sel_in(selIn),
        .mode(mode), .hold(hold), .data_out(dataOutB), .sel_out(selOutB),
        .new_chan(newChanB), .wrap(wrapB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan is modelled as a position in an unrolled sequence of
    // dwell*8 samples; the channel is simply position / dwell.
    function automatic model_t modelStep(model_t m, int dwell, bit r, bit md,
                                         bit hd, logic [2:0] s, logic [31:0] din);
        model_t n;
        int cur;
        logic [2:0] curSel;
        n = m;
        if (r) begin
            n.inScan = 0; n.pos = 0; n.first = 1;
            n.data = '0; n.sel = '0; n.nc = 1'b0; n.wr = 1'b0;
            return n;
        end
        cur = m.inScan ? (m.pos / dwell) % 8 : int'(s);
        curSel = cur[2:0];
        n.data  = din[cur*4 +: 4];
        n.nc    = m.first || (curSel != m.sel);
        n.sel   = curSel;
        n.first = 0;
        n.wr    = 1'b0;
        if (!m.inScan) begin
            if (md) begin
                n.inScan = 1;
                n.pos    = 0;
            end
        end else if (!md) begin
            n.inScan = 0;
        end else if (!hd) begin
            n.pos = (m.pos + 1) % (dwell * 8);
            if (n.pos == 0) n.wr = 1'b1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        mA = modelStep(mA, 3, rst, mode, hold, selIn, dataIn);
        mB = modelStep(mB, 1, rst, mode, hold, selIn, dataIn);
        @(posedge clk);
        #1;
        checkOutput("A.data", 32'(dataOutA), 32'(mA.data));
        checkOutput("A.sel",  32'(selOutA),  32'(mA.sel));
        checkOutput("A.new",  32'(newChanA), 32'(mA.nc));
        checkOutput("A.wrap", 32'(wrapA),    32'(mA.wr));
        checkOutput("B.data", 32'(dataOutB), 32'(mB.data));
        checkOutput("B.sel",  32'(selOutB),  32'(mB.sel));
        checkOutput("B.new",  32'(newChanB), 32'(mB.nc));
        checkOutput("B.wrap", 32'(wrapB),    32'(mB.wr));
    endtask

    initial begin
        int ncCount;
        int wrCount;
        mA = '{inScan: 0, pos: 0, first: 1, data: '0, sel: '0, nc: 1'b0, wr: 1'b0};
        mB = mA;
        rst = 1'b1; mode = 1'b0; hold = 1'b0; selIn = '0;
        for (int k = 0; k < 8; k++) dataIn[k*4 +: 4] = 4'(k + 8);

        applyStimulus();
        applyStimulus();
        checkOutput("rst.data", 32'(dataOutA), 32'd0);
        checkOutput("rst.new",  32'(newChanA), 32'd0);
        checkOutput("rst.wrap", 32'(wrapA),    32'd0);

        rst = 1'b0; selIn = 3'd5;
        applyStimulus();
        checkOutput("direct5.data", 32'(dataOutA), 32'd13);
        checkOutput("direct5.sel",  32'(selOutA),  32'd5);
        checkOutput("direct5.new",  32'(newChanA), 32'd1);
        applyStimulus();
        checkOutput("direct5.newLow", 32'(newChanA), 32'd0);

        selIn = 3'd2;
        applyStimulus();
        checkOutput("direct2.data", 32'(dataOutA), 32'd10);
        checkOutput("direct2.new",  32'(newChanA), 32'd1);
        dataIn[11:8] = 4'hF;
        applyStimulus();
        checkOutput("live.data", 32'(dataOutA), 32'hF);
        checkOutput("live.new",  32'(newChanA), 32'd0);
        dataIn[11:8] = 4'd10;

        mode = 1'b1;
        applyStimulus();
        ncCount = 0; wrCount = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus();
            ncCount += int'(newChanA);
            wrCount += int'(wrapA);
        end
        checkOutput("scanLap.newCount",  32'(ncCount), 32'd8);
        checkOutput("scanLap.wrapCount", 32'(wrCount), 32'd1);
        for (int i = 0; i < 11; i++) applyStimulus();

        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("hold.data", 32'(dataOutA), 32'd11);
            checkOutput("hold.new",  32'(newChanA), 32'd0);
            checkOutput("hold.wrap", 32'(wrapA),    32'd0);
        end
        hold = 1'b0;
        applyStimulus();
        checkOutput("release.data", 32'(dataOutA), 32'd11);
        applyStimulus();
        checkOutput("advance.data", 32'(dataOutA), 32'd12);
        checkOutput("advance.new",  32'(newChanA), 32'd1);

        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput("atCh6.sel", 32'(selOutA), 32'd6);
        mode = 1'b0; selIn = 3'd1;
        applyStimulus();
        applyStimulus();
        checkOutput("exit.data", 32'(dataOutA), 32'd9);
        checkOutput("exit.new",  32'(newChanA), 32'd1);

        mode = 1'b1;
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("reentry.data", 32'(dataOutA), 32'd8);
        end
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("atCh4.sel", 32'(selOutA), 32'd4);

        rst = 1'b1;
        applyStimulus();
        checkOutput("midRst.data", 32'(dataOutA), 32'd0);
        checkOutput("midRst.sel",  32'(selOutA),  32'd0);
        checkOutput("midRst.new",  32'(newChanA), 32'd0);
        checkOutput("midRst.wrap", 32'(wrapA),    32'd0);

        rst = 1'b0; mode = 1'b1; selIn = 3'd3;
        applyStimulus();
        ncCount = 0; wrCount = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            ncCount += int'(newChanB);
            wrCount += int'(wrapB);
        end
        checkOutput("dwell1.newCount",  32'(ncCount), 32'd16);
        checkOutput("dwell1.wrapCount", 32'(wrCount), 32'd2);

        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            hold  = ($urandom_range(0, 3) == 0);
            selIn = 3'($urandom);
            if ($urandom_range(0, 3) == 0) dataIn = $urandom;
            applyStimulus();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
